// File: rtl/toggle_cover_detect.sv
// Toggle-coverage edge detector: one-shot per-bit pulse once a probe bit has
// been seen rising and falling since reset/clear, plus running covered count.
module toggle_cover_detect #(
  parameter int WIDTH = 58,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] valid,
  output logic [CNT_W-1:0] covered_cnt,
  output logic             all_covered
);

  localparam logic [CNT_W-1:0] LP_FULL = CNT_W'(WIDTH);

  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_rose;
  logic [WIDTH-1:0] r_fell;
  logic [WIDTH-1:0] r_done;
  logic [WIDTH-1:0] r_valid;
  logic             r_armed;
  logic [CNT_W-1:0] r_cnt;
  logic             r_all;

  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_rose_n;
  logic [WIDTH-1:0] w_fell_n;
  logic [WIDTH-1:0] w_newly;
  logic [CNT_W-1:0] w_cnt_n;

  function automatic logic [CNT_W-1:0] f_popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < WIDTH; i++) s = s + CNT_W'(v[i]);
    return s;
  endfunction

  // The done mask bounds the count at WIDTH, so no saturation is needed here.
  always_comb begin
    w_rise   = sig & ~r_prev;
    w_fall   = ~sig & r_prev;
    w_rose_n = r_rose | w_rise;
    w_fell_n = r_fell | w_fall;
    w_newly  = w_rose_n & w_fell_n & ~r_done;
    w_cnt_n  = r_cnt + f_popcount(w_newly);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prev  <= '0;
      r_rose  <= '0;
      r_fell  <= '0;
      r_done  <= '0;
      r_valid <= '0;
      r_armed <= 1'b0;
      r_cnt   <= '0;
      r_all   <= 1'b0;
    end else if (clear) begin
      // prev is kept: the next enabled cycle re-baselines anyway
      r_rose  <= '0;
      r_fell  <= '0;
      r_done  <= '0;
      r_valid <= '0;
      r_armed <= 1'b0;
      r_cnt   <= '0;
      r_all   <= 1'b0;
    end else if (!en) begin
      r_valid <= '0;
      r_armed <= 1'b0;
    end else if (!r_armed) begin
      // Baseline cycle: transitions seen across a disabled window are discarded
      r_prev  <= sig;
      r_armed <= 1'b1;
      r_valid <= '0;
    end else begin
      r_prev  <= sig;
      r_rose  <= w_rose_n;
      r_fell  <= w_fell_n;
      r_done  <= r_done | w_newly;
      r_valid <= w_newly;
      r_cnt   <= w_cnt_n;
      r_all   <= (w_cnt_n == LP_FULL);
    end
  end

  assign valid       = r_valid;
  assign covered_cnt = r_cnt;
  assign all_covered = r_all;

endmodule

// File: tb/tb_toggle_cover_detect.sv
// Bench for toggle_cover_detect: directed scenarios plus randomized traffic
// checked against a per-bit rise/fall counting model.
module tb_toggle_cover_detect;

  localparam int WIDTH = 58;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clock;
  logic             reset;
  logic             en;
  logic             clear;
  logic [WIDTH-1:0] sig;
  logic [WIDTH-1:0] valid;
  logic [CNT_W-1:0] covered_cnt;
  logic             all_covered;

  int n_cmp;
  int n_bad;

  // Reference model: counts of observed rises/falls per bit since reset/clear
  int               m_nrise [WIDTH];
  int               m_nfall [WIDTH];
  bit               m_cred  [WIDTH];
  bit               m_armed;
  logic [WIDTH-1:0] m_last;
  logic [WIDTH-1:0] m_valid;
  int               m_count;

  toggle_cover_detect #(.WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .en          (en),
    .clear       (clear),
    .sig         (sig),
    .valid       (valid),
    .covered_cnt (covered_cnt),
    .all_covered (all_covered)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    for (int i = 0; i < WIDTH; i++) begin
      m_nrise[i] = 0;
      m_nfall[i] = 0;
      m_cred[i]  = 1'b0;
    end
    m_armed = 1'b0;
    m_last  = '0;
    m_valid = '0;
    m_count = 0;
  endtask

  task automatic model_edge();
    if (!reset) begin
      model_reset();
    end else if (clear) begin
      for (int i = 0; i < WIDTH; i++) begin
        m_nrise[i] = 0;
        m_nfall[i] = 0;
        m_cred[i]  = 1'b0;
      end
      m_armed = 1'b0;
      m_valid = '0;
      m_count = 0;
    end else if (!en) begin
      m_armed = 1'b0;
      m_valid = '0;
    end else if (!m_armed) begin
      m_armed = 1'b1;
      m_last  = sig;
      m_valid = '0;
    end else begin
      m_valid = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (sig[i] && !m_last[i]) m_nrise[i]++;
        if (!sig[i] && m_last[i]) m_nfall[i]++;
        if (m_nrise[i] > 0 && m_nfall[i] > 0 && !m_cred[i]) begin
          m_cred[i]  = 1'b1;
          m_valid[i] = 1'b1;
          m_count++;
        end
      end
      m_last = sig;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    en    = 1'b1;
    clear = 1'b0;
    sig   = '0;
    repeat (3) tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (valid !== '0 || covered_cnt !== '0 || all_covered !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: valid=%h cnt=%0d all=%b required 0/0/0", valid, covered_cnt, all_covered);
    end
  endtask

  task automatic test_single_bit();
    logic [WIDTH-1:0] exp_v;
    do_reset();
    sig = '0; tick();           // baseline
    sig = 1;  tick();           // rise
    n_cmp++;
    if (valid !== '0) begin
      n_bad++;
      $display("FAIL bit0_after_rise: valid=%h required 0", valid);
    end
    sig = 0;  tick();           // fall completes coverage
    exp_v = 1;
    n_cmp++;
    if (valid !== exp_v || covered_cnt !== CNT_W'(1)) begin
      n_bad++;
      $display("FAIL bit0_pulse: valid=%h cnt=%0d required %h/1", valid, covered_cnt, exp_v);
    end
    tick();
    n_cmp++;
    if (valid !== '0 || covered_cnt !== CNT_W'(1)) begin
      n_bad++;
      $display("FAIL bit0_one_cycle: valid=%h cnt=%0d required 0/1", valid, covered_cnt);
    end
  endtask

  task automatic test_repeat_toggle();
    int pulses;
    logic [WIDTH-1:0] b5;
    b5 = '0;
    b5[5] = 1'b1;
    do_reset();
    sig = '0; tick();
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      sig = (k % 2 == 0) ? b5 : '0;
      tick();
      if (valid === b5) pulses++;
      else begin
        n_cmp++;
        if (valid !== '0) begin
          n_bad++;
          $display("FAIL bit5_stray: step %0d valid=%h required 0", k, valid);
        end
      end
    end
    n_cmp++;
    if (pulses != 1 || covered_cnt !== CNT_W'(1)) begin
      n_bad++;
      $display("FAIL bit5_once: pulses=%0d cnt=%0d required 1/1", pulses, covered_cnt);
    end
  endtask

  task automatic test_all_bits();
    do_reset();
    sig = '0; tick();
    sig = '1; tick();
    n_cmp++;
    if (valid !== '0 || all_covered !== 1'b0) begin
      n_bad++;
      $display("FAIL all_after_rise: valid=%h all=%b required 0/0", valid, all_covered);
    end
    sig = '0; tick();
    n_cmp++;
    if (valid !== {WIDTH{1'b1}} || covered_cnt !== CNT_W'(WIDTH) || all_covered !== 1'b1) begin
      n_bad++;
      $display("FAIL all_pulse: valid=%h cnt=%0d all=%b required all-ones/%0d/1", valid, covered_cnt, all_covered, WIDTH);
    end
    tick();
    n_cmp++;
    if (valid !== '0 || covered_cnt !== CNT_W'(WIDTH) || all_covered !== 1'b1) begin
      n_bad++;
      $display("FAIL all_hold: valid=%h cnt=%0d all=%b required 0/%0d/1", valid, covered_cnt, all_covered, WIDTH);
    end
  endtask

  task automatic test_enable_gap();
    logic [WIDTH-1:0] b3;
    b3 = '0;
    b3[3] = 1'b1;
    do_reset();
    sig = '0; tick();
    sig = b3; tick();                     // rise recorded
    en = 1'b0; sig = '0; tick();          // fall hidden by disable
    en = 1'b1; tick();                    // re-baseline
    n_cmp++;
    if (valid !== '0 || covered_cnt !== '0) begin
      n_bad++;
      $display("FAIL en_gap_no_pulse: valid=%h cnt=%0d required 0/0", valid, covered_cnt);
    end
    sig = b3; tick();
    n_cmp++;
    if (valid !== '0 || covered_cnt !== '0) begin
      n_bad++;
      $display("FAIL en_gap_rise: valid=%h cnt=%0d required 0/0", valid, covered_cnt);
    end
    sig = '0; tick();
    n_cmp++;
    if (valid !== b3 || covered_cnt !== CNT_W'(1)) begin
      n_bad++;
      $display("FAIL en_gap_pulse: valid=%h cnt=%0d required %h/1", valid, covered_cnt, b3);
    end
  endtask

  task automatic test_clear();
    logic [WIDTH-1:0] b7;
    b7 = '0;
    b7[7] = 1'b1;
    do_reset();
    sig = '0; tick();
    sig = b7; tick();
    sig = '0; clear = 1'b1; tick();       // completing edge swallowed by clear
    n_cmp++;
    if (valid !== '0 || covered_cnt !== '0 || all_covered !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_drop: valid=%h cnt=%0d all=%b required 0/0/0", valid, covered_cnt, all_covered);
    end
    clear = 1'b0;
    tick();                               // baseline
    sig = b7; tick();
    sig = '0; tick();
    n_cmp++;
    if (valid !== b7 || covered_cnt !== CNT_W'(1)) begin
      n_bad++;
      $display("FAIL clear_refresh: valid=%h cnt=%0d required %h/1", valid, covered_cnt, b7);
    end
  endtask

  task automatic test_async_reset();
    logic [WIDTH-1:0] m20;
    m20 = (58'd1 << 20) - 58'd1;
    do_reset();
    sig = '0;  tick();
    sig = m20; tick();
    sig = '0;  tick();
    n_cmp++;
    if (covered_cnt !== CNT_W'(20) || valid !== m20) begin
      n_bad++;
      $display("FAIL pre_reset_cnt: cnt=%0d valid=%h required 20/%h", covered_cnt, valid, m20);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;                                   // still well before next posedge
    n_cmp++;
    if (valid !== '0 || covered_cnt !== '0 || all_covered !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: valid=%h cnt=%0d all=%b required 0/0/0", valid, covered_cnt, all_covered);
    end
    tick();
    reset = 1'b1;
    sig = '1; tick();                     // baseline after reset
    n_cmp++;
    if (valid !== '0 || covered_cnt !== '0) begin
      n_bad++;
      $display("FAIL post_reset_baseline: valid=%h cnt=%0d required 0/0", valid, covered_cnt);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] flip;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      flip  = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      sig   = sig ^ flip;
      en    = ($urandom_range(0, 7) != 0);
      clear = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (valid !== '0 || covered_cnt !== '0 || all_covered !== 1'b0) begin
          n_bad++;
          $display("FAIL rand_async_reset: cyc %0d valid=%h cnt=%0d all=%b", c, valid, covered_cnt, all_covered);
        end
        tick();
        reset = 1'b1;
      end else begin
        tick();
      end
      n_cmp++;
      if (valid !== m_valid || covered_cnt !== CNT_W'(m_count) || all_covered !== (m_count == WIDTH)) begin
        n_bad++;
        $display("FAIL rand_cycle: cyc %0d valid=%h cnt=%0d all=%b required %h/%0d/%b",
                 c, valid, covered_cnt, all_covered, m_valid, m_count, (m_count == WIDTH));
      end
    end
    clear = 1'b0;
    en    = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    en    = 1'b0;
    clear = 1'b0;
    sig   = '0;
    model_reset();
    #1;
    test_reset();
    test_single_bit();
    test_repeat_toggle();
    test_all_bits();
    test_enable_gap();
    test_clear();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
